// File: rtl/ef_auto_range_ctrl.sv
// Auto-ranging sequencer for the extremum finder: walks EF_log_shift until the threshold span fits the window.
// Optional build macro TC_AVG_EN enables averaging of each published threshold with the previous one.
module ef_auto_range_ctrl #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int SHIFT_MAX        = 7,
  parameter int SETTLE_WINDOWS   = 1
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic                        CFG_enable,
  input  logic [4:0]                  CFG_log_count,
  input  logic [2:0]                  CFG_shift_init,
  input  logic [AXIS_TDATA_WIDTH-1:0] CFG_span_low,
  input  logic [AXIS_TDATA_WIDTH-1:0] CFG_span_high,
  input  logic [AXIS_TDATA_WIDTH-1:0] EF_lower_treshold,
  input  logic [AXIS_TDATA_WIDTH-1:0] EF_upper_treshold,
  output logic [4:0]                  EF_log_count,
  output logic [2:0]                  EF_log_shift,
  output logic [AXIS_TDATA_WIDTH-1:0] TC_lower,
  output logic [AXIS_TDATA_WIDTH-1:0] TC_upper,
  output logic                        TC_valid,
  output logic                        TC_update,
  output logic                        TC_saturated,
  output logic [1:0]                  TC_state,
  output logic [15:0]                 TC_window_count
);

  localparam int W = AXIS_TDATA_WIDTH;
  localparam logic [2:0] SHIFT_MAX_L   = 3'(SHIFT_MAX);
  localparam logic [3:0] SETTLE_INIT_L = 4'(SETTLE_WINDOWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] ph;
  logic [3:0]  settle_cnt;

  logic               ph_zero, boundary;
  logic signed [W:0]  span, span_low_x, span_high_x;
  logic               do_eval, pub_en, pub_sat, shift_dec, shift_inc;
  logic [2:0]         shift_init_clamped;
  logic [W-1:0]       pub_lower, pub_upper;

  assign TC_state = state;
  assign ph_zero  = (ph == '0);
  // The finder's window is 2^log_count+1 clocks long; wrap in lockstep with it.
  assign boundary = (ph == (32'd1 << EF_log_count));

  assign span        = $signed({EF_upper_treshold[W-1], EF_upper_treshold})
                     - $signed({EF_lower_treshold[W-1], EF_lower_treshold});
  assign span_low_x  = $signed({1'b0, CFG_span_low});
  assign span_high_x = $signed({1'b0, CFG_span_high});
  assign shift_init_clamped = (CFG_shift_init > SHIFT_MAX_L) ? SHIFT_MAX_L : CFG_shift_init;

  assign do_eval = CFG_enable && ph_zero &&
                   ((state == RUN) || ((state == SETTLE) && (settle_cnt == 4'd0)));

  // Too-small takes precedence; negative spans are simply ignored.
  always_comb begin
    pub_en    = 1'b0;
    pub_sat   = 1'b0;
    shift_dec = 1'b0;
    shift_inc = 1'b0;
    if (span < 0) begin
      pub_en = 1'b0;
    end else if (span < span_low_x) begin
      if (EF_log_shift != 3'd0) shift_dec = 1'b1;
      else begin
        pub_en  = 1'b1;
        pub_sat = 1'b1;
      end
    end else if (span > span_high_x) begin
      if (EF_log_shift < SHIFT_MAX_L) shift_inc = 1'b1;
      else begin
        pub_en  = 1'b1;
        pub_sat = 1'b1;
      end
    end else begin
      pub_en = 1'b1;
    end
  end

`ifdef TC_AVG_EN
  logic signed [W:0] diff_lo, diff_hi;

  // prev + ((new-prev)>>>1), computed at W+1 bits and truncated back to W.
  always_comb begin
    diff_lo   = $signed({EF_lower_treshold[W-1], EF_lower_treshold}) - $signed({TC_lower[W-1], TC_lower});
    diff_hi   = $signed({EF_upper_treshold[W-1], EF_upper_treshold}) - $signed({TC_upper[W-1], TC_upper});
    pub_lower = TC_valid ? (TC_lower + diff_lo[W:1]) : EF_lower_treshold;
    pub_upper = TC_valid ? (TC_upper + diff_hi[W:1]) : EF_upper_treshold;
  end
`else
  assign pub_lower = EF_lower_treshold;
  assign pub_upper = EF_upper_treshold;
`endif

  // Disable overrides everything, including an evaluation due on the same edge.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state           <= IDLE;
      ph              <= '0;
      settle_cnt      <= '0;
      EF_log_count    <= '0;
      EF_log_shift    <= '0;
      TC_lower        <= '0;
      TC_upper        <= '0;
      TC_valid        <= 1'b0;
      TC_update       <= 1'b0;
      TC_saturated    <= 1'b0;
      TC_window_count <= '0;
    end else begin
      TC_update <= 1'b0;
      ph        <= boundary ? '0 : ph + 32'd1;
      if (ph_zero) EF_log_count <= CFG_log_count;

      if (!CFG_enable) begin
        state    <= IDLE;
        TC_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ph_zero) begin
            state        <= SETTLE;
            EF_log_shift <= shift_init_clamped;
            settle_cnt   <= SETTLE_INIT_L;
          end
          SETTLE: if (ph_zero) begin
            if (settle_cnt == 4'd0) state <= RUN;
            else settle_cnt <= settle_cnt - 4'd1;
          end
          RUN: state <= RUN;
          default: state <= IDLE;
        endcase

        if (do_eval) begin
          TC_window_count <= TC_window_count + 16'd1;
          if (shift_dec) EF_log_shift <= EF_log_shift - 3'd1;
          if (shift_inc) EF_log_shift <= EF_log_shift + 3'd1;
          if (pub_en) begin
            TC_lower     <= pub_lower;
            TC_upper     <= pub_upper;
            TC_valid     <= 1'b1;
            TC_update    <= 1'b1;
            TC_saturated <= pub_sat;
          end
        end
      end
    end
  end

endmodule
